pc_fetch: RTL
=============

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 stall  in  1  hazard hold from decode/execute; freezes PC and IF/ID register.
REQ-004 mem_busy  in  1  instruction memory used by a data access this cycle; fetch not possible.
REQ-005 set_pc  in  1  redirect request from jump/branch control.
REQ-006 set_pc_value  in  16  redirect target address.
REQ-007 inst_data  in  16  instruction word read combinationally at inst_addr.
REQ-008 inst_addr  out  16  fetch address; SHALL equal the PC register combinationally.
REQ-009 id_pc  out  16  address of the instruction held in IF/ID.
REQ-010 id_inst  out  16  instruction held in IF/ID; NOP = 16'h0800 when id_valid=0.
REQ-011 id_valid  out  1  IF/ID holds a real fetched instruction.

Function
REQ-012 Internal state SHALL be: pc[15:0], pend_valid, pend_target[15:0], id_pc, id_inst, id_valid.
REQ-013 Per-cycle priority SHALL be: rst > stall > redirect (set_pc or pend_valid) > mem_busy > sequential.
REQ-014 Sequential cycle (no stall, no busy, no redirect): IF/ID <= {pc, inst_data, valid=1}; pc <= pc+1, wrapping 16'hFFFF -> 16'h0000.
REQ-015 mem_busy without redirect or stall: pc held; IF/ID <= bubble {id_pc=pc, id_inst=16'h0800, id_valid=0}.
REQ-016 stall: pc, IF/ID held unchanged regardless of mem_busy.
REQ-017 set_pc while stall: pend_valid <= 1, pend_target <= set_pc_value; a later set_pc during the same stall overwrites pend_target.
REQ-018 The effective redirect target SHALL be set_pc_value when set_pc=1, else pend_target; a live set_pc overrides a pending one.
REQ-019 Redirect taken (see Configuration for IF/ID content): pc <= effective target; pend_valid <= 0 in the same cycle.
REQ-020 Redirect is accepted at most once; pend_valid SHALL never stay set in a cycle where a redirect is taken.
REQ-021 Latency: target appears on inst_addr exactly one cycle after the accepting edge; first target instruction reaches IF/ID one cycle later.
REQ-022 pc increment and target load SHALL be 16-bit unsigned, no sign extension or carry out.

Reset
REQ-023 On rst at a rising edge: pc=16'h0000, pend_valid=0, pend_target=16'h0000, id_pc=16'h0000, id_inst=16'h0800, id_valid=0.
REQ-024 rst SHALL discard any pending redirect and override stall, mem_busy and set_pc in that cycle.
REQ-025 First fetch after reset release SHALL be address 16'h0000.

Configuration
REQ-026 Macro PC_DELAY_SLOT_EN selects branch delay-slot behaviour.
REQ-027 With PC_DELAY_SLOT_EN: on redirect without mem_busy, IF/ID <= {pc, inst_data, valid=1} (delay slot executes); on redirect with mem_busy, the redirect SHALL be captured to pend and pc held with a bubble, applied on the first cycle with !stall && !mem_busy after fetching the delay slot.
REQ-028 Without PC_DELAY_SLOT_EN: on redirect IF/ID <= bubble (id_inst=16'h0800, id_valid=0) and pc <= target, regardless of mem_busy.

Verification
REQ-029 Reset then 4 free cycles, inst_data=16'h4801 -> inst_addr 0,1,2,3; id_pc 0,1,2; id_valid=1.
REQ-030 pc=16'hFFFF, free cycle -> inst_addr=16'h0000 next cycle, id_pc=16'hFFFF.
REQ-031 pc=16'h0010, set_pc=1, value=16'h0040 -> next inst_addr=16'h0040; id_pc=16'h0010 valid=1 with macro, id_valid=0/id_inst=16'h0800 without.
REQ-032 stall=1 for 3 cycles, set_pc pulse value=16'h0100 in cycle 1 -> pc held; after stall drops, inst_addr=16'h0100 one cycle later; pend_valid=0 afterwards.
REQ-033 pc=16'h0020, mem_busy=1 one cycle -> inst_addr stays 16'h0020, bubble in IF/ID, then fetch resumes at 16'h0020.
REQ-034 Pending redirect 16'h0200 with rst asserted before stall drops -> inst_addr=16'h0000, pend_valid=0, target never fetched.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus for pc_fetch: hazard/redirect controls, instruction memory
// port and the IF/ID register outputs.
interface pc_fetch_if;
  logic        stall;
  logic        mem_busy;
  logic        set_pc;
  logic [15:0] set_pc_value;
  logic [15:0] inst_data;
  logic [15:0] inst_addr;
  logic [15:0] id_pc;
  logic [15:0] id_inst;
  logic        id_valid;

  modport master (
    output stall, mem_busy, set_pc, set_pc_value, inst_data,
    input  inst_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    input  stall, mem_busy, set_pc, set_pc_value, inst_data,
    output inst_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, redirect capture during stalls, IF/ID register.
// Define PC_DELAY_SLOT_EN to execute the instruction after a jump/branch (delay slot).
module pc_fetch (
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.slave  bus
);

  localparam logic [15:0] NOP = 16'h0800;

  logic [15:0] pc;
  logic        pend_valid;
  logic [15:0] pend_target;
  logic [15:0] id_pc_q;
  logic [15:0] id_inst_q;
  logic        id_valid_q;

  logic        redirect;
  logic [15:0] redirect_target;

  always_comb begin
    redirect        = bus.set_pc | pend_valid;
    redirect_target = bus.set_pc ? bus.set_pc_value : pend_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      id_pc_q     <= '0;
      id_inst_q   <= NOP;
      id_valid_q  <= 1'b0;
    end else if (bus.stall) begin
      // Redirects arriving while frozen are remembered; the newest one wins.
      if (bus.set_pc) begin
        pend_valid  <= 1'b1;
        pend_target <= bus.set_pc_value;
      end
    end else if (redirect) begin
`ifdef PC_DELAY_SLOT_EN
      if (bus.mem_busy) begin
        // Delay slot cannot be fetched yet: park the target and insert a bubble.
        pend_valid  <= 1'b1;
        pend_target <= redirect_target;
        id_pc_q     <= pc;
        id_inst_q   <= NOP;
        id_valid_q  <= 1'b0;
      end else begin
        id_pc_q     <= pc;
        id_inst_q   <= bus.inst_data;
        id_valid_q  <= 1'b1;
        pc          <= redirect_target;
        pend_valid  <= 1'b0;
      end
`else
      id_pc_q    <= pc;
      id_inst_q  <= NOP;
      id_valid_q <= 1'b0;
      pc         <= redirect_target;
      pend_valid <= 1'b0;
`endif
    end else if (bus.mem_busy) begin
      id_pc_q    <= pc;
      id_inst_q  <= NOP;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= pc;
      id_inst_q  <= bus.inst_data;
      id_valid_q <= 1'b1;
      pc         <= pc + 16'd1;
    end
  end

  assign bus.inst_addr = pc;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_valid  = id_valid_q;

endmodule
